// File: rtl/mdu_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_unit
// Purpose  : Iterative restoring divider (DIV/DIVU/REM/REMU) with ROB tag,
//            valid/ready in and out, flush, and fast path for /0 and overflow.
// Revision : 1.0
// ============================================================================
module mdu_div_unit #(
    parameter int XLEN           = 32,
    parameter int TAG_W          = 6,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             accept;
    logic             signed_op;
    logic             rs1_neg, rs2_neg;
    logic [XLEN-1:0]  abs1, abs2;
    logic             div_zero, overflow, special;
    logic [XLEN-1:0]  special_result;
    logic [XLEN-1:0]  step_quo, step_rem;
    logic [XLEN:0]    shifted;
    logic [XLEN-1:0]  fin_quo, fin_rem, fin_result;

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

    assign accept    = in_valid & in_ready & ~flush;
    assign signed_op = ~in_op[0];
    assign rs1_neg   = signed_op & in_rs1[XLEN-1];
    assign rs2_neg   = signed_op & in_rs2[XLEN-1];
    // -INT_MIN wraps back to INT_MIN, which is exactly its unsigned magnitude
    assign abs1      = rs1_neg ? -in_rs1 : in_rs1;
    assign abs2      = rs2_neg ? -in_rs2 : in_rs2;
    assign div_zero  = (in_rs2 == '0);
    assign overflow  = signed_op & (in_rs1 == INT_MIN) & (&in_rs2);
    assign special   = div_zero | overflow;

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = in_op[1] ? in_rs1 : '1;
        end else begin
            special_result = in_op[1] ? '0 : in_rs1;
        end
    end

    // Dividend bits shift out of quo's top while quotient bits fill its bottom
    always_comb begin
        step_quo = quo_q;
        step_rem = rem_q;
        shifted  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted  = {step_rem, step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (shifted >= {1'b0, divisor_q}) begin
                shifted     = shifted - {1'b0, divisor_q};
                step_quo[0] = 1'b1;
            end
            step_rem = shifted[XLEN-1:0];
        end
    end

    assign fin_quo    = neg_quo_q ? -step_quo : step_quo;
    assign fin_rem    = neg_rem_q ? -step_rem : step_rem;
    assign fin_result = is_rem_q ? fin_rem : fin_quo;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_rem_d     = is_rem_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        divisor_d    = divisor_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        tag_d        = tag_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tag_d    = in_tag;
                    is_rem_d = in_op[1];
                    if (special) begin
                        state_d      = S_DONE;
                        out_valid_d  = 1'b1;
                        out_result_d = special_result;
                        out_tag_d    = in_tag;
                    end else begin
                        state_d   = S_BUSY;
                        cnt_d     = '0;
                        quo_d     = abs1;
                        rem_d     = '0;
                        divisor_d = abs2;
                        neg_quo_d = rs1_neg ^ rs2_neg;
                        neg_rem_d = rs1_neg;
                    end
                end
            end
            S_BUSY: begin
                quo_d = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d      = S_DONE;
                    out_valid_d  = 1'b1;
                    out_result_d = fin_result;
                    out_tag_d    = tag_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_rem_q     <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            divisor_q    <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_rem_q     <= is_rem_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            divisor_q    <= divisor_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_div_unit
// Purpose  : Self-checking bench for mdu_div_unit at BITS_PER_CYCLE 1 and 2.
// Revision : 1.0
// ============================================================================
module tb_mdu_div_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, sel;
    logic [1:0]  in_op;
    logic [31:0] in_rs1, in_rs2;
    logic [5:0]  in_tag;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] out_result1;
    logic [5:0]  out_tag1;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] out_result2;
    logic [5:0]  out_tag2;

    logic        in_ready_m, out_valid_m;
    logic [31:0] out_result_m;
    logic [5:0]  out_tag_m;

    // sel routes the handshake to one instance; the other stays idle
    assign in_valid1    = in_valid & ~sel;
    assign in_valid2    = in_valid & sel;
    assign out_ready1   = out_ready & ~sel;
    assign out_ready2   = out_ready & sel;
    assign in_ready_m   = sel ? in_ready2 : in_ready1;
    assign out_valid_m  = sel ? out_valid2 : out_valid1;
    assign out_result_m = sel ? out_result2 : out_result1;
    assign out_tag_m    = sel ? out_tag2 : out_tag1;

    mdu_div_unit #(.XLEN(32), .TAG_W(6), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_tag(out_tag1)
    );

    mdu_div_unit #(.XLEN(32), .TAG_W(6), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_result(out_result2), .out_tag(out_tag2)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  tag;
    } sb_t;

    vec_t vecs[16];
    sb_t  sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        case (op)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input logic [31:0] exp, input int lat_exp,
                         input int hold);
        int          lat;
        int          bad;
        sb_t         e;
        logic [31:0] held_res;
        logic [5:0]  held_tag;
        @(negedge clk);
        chk("in_ready_idle", in_ready_m, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        sb_q.push_back('{res: exp, tag: tag});
        @(negedge clk);
        // inputs wander while the op is in flight; none of it may be accepted
        in_op  = 2'($urandom);
        in_rs1 = $urandom;
        in_rs2 = $urandom;
        in_tag = 6'($urandom);
        lat    = 1;
        while (!out_valid_m && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, lat_exp);
        if (!out_valid_m) begin
            in_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        held_res = out_result_m;
        held_tag = out_tag_m;
        bad      = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid_m !== 1'b1 || out_result_m !== held_res ||
                out_tag_m !== held_tag || in_ready_m !== 1'b0) bad++;
        end
        if (hold > 0) chk("hold_stable", bad, 0);
        chk("in_ready_done", in_ready_m, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb_q.pop_front();
        chk("result", out_result_m, e.res);
        chk("tag", out_tag_m, e.tag);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", out_valid_m, 0);
        chk("in_ready_after_hs", in_ready_m, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid_m, 0);
        chk("rst_out_result", out_result_m, 0);
        chk("rst_out_tag", out_tag_m, 0);
        chk("rst_in_ready", in_ready_m, 1);
    endtask

    initial begin
        int          cnt;
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          sp;

        vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,        6'd5,  32'hFFFF_FFFD, 33, 10};
        vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        6'd6,  32'hFFFF_FFFF, 33, 0};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,        6'd7,  32'hFFFF_FFFF, 33, 0};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,        6'd8,  32'd2,         33, 0};
        vecs[4]  = '{2'b00, 32'h8000_0000, 32'd1,        6'd9,  32'h8000_0000, 33, 0};
        vecs[5]  = '{2'b00, 32'd5,         32'd0,        6'd10, 32'hFFFF_FFFF, 1,  0};
        vecs[6]  = '{2'b10, 32'h0000_1234, 32'd0,        6'd11, 32'h0000_1234, 1,  0};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 32'h8000_0000, 1, 3};
        vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 32'd0,        1,  0};
        vecs[9]  = '{2'b01, 32'h0000_1234, 32'd0,        6'd14, 32'hFFFF_FFFF, 1,  0};
        vecs[10] = '{2'b11, 32'd7,         32'd0,        6'd15, 32'd7,         1,  0};
        vecs[11] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 6'd16, 32'hFFFF_FFFD, 33, 0};
        vecs[12] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 6'd17, 32'd1,        33, 0};
        vecs[13] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 6'd18, 32'd0,        33, 0};
        vecs[14] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 6'd19, 32'h8000_0000, 33, 0};
        vecs[15] = '{2'b00, 32'h8000_0000, 32'd3,        6'd20, 32'hD555_5556, 33, 0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 1'b0;
        in_op     = 2'b00;
        in_rs1    = '0;
        in_rs2    = '0;
        in_tag    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("init_out_valid", out_valid_m, 0);
        chk("init_out_result", out_result_m, 0);
        chk("init_out_tag", out_tag_m, 0);
        chk("init_in_ready", in_ready_m, 1);

        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
                  vecs[i].lat, vecs[i].hold);

        // flush at BUSY cycle 12, held one more cycle into IDLE with in_valid high
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd100; in_rs2 = 32'd3; in_tag = 6'd40;
        @(negedge clk);
        in_tag = 6'd33;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_in_ready", in_ready_m, 1);
        chk("flush_busy_out_valid", out_valid_m, 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_no_accept", in_ready_m, 1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_m) cnt++;
        end
        chk("flush_no_result", cnt, 0);
        do_op(2'b01, 32'd50, 32'd7, 6'd41, 32'd7, 33, 0);

        // flush in DONE coinciding with out_ready
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'd5; in_rs2 = 32'd0; in_tag = 6'd42;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flush_done_valid_pre", out_valid_m, 1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_done_valid", out_valid_m, 0);
        chk("flush_done_in_ready", in_ready_m, 1);

        // reset mid-BUSY
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b11; in_rs1 = 32'd999; in_rs2 = 32'd10; in_tag = 6'd43;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        do_reset();
        // reset while DONE holds a non-zero result
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b10; in_rs1 = 32'h1234; in_rs2 = 32'd0; in_tag = 6'd44;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_done_valid_pre", out_valid_m, 1);
        do_reset();

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 500; i++) begin
                op = 2'($urandom);
                a  = $urandom;
                b  = $urandom;
                case ($urandom_range(0, 9))
                    0: b = 32'd0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = $urandom_range(1, 15);
                    3: a = $urandom_range(0, 1000);
                    4: b = -$urandom_range(1, 15);
                    default: ;
                endcase
                sp = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
                do_op(op, a, b, 6'(i), ref_div(op, a, b), sp ? 1 : (s == 0 ? 33 : 17), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
